// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: per-cycle hazard control for an in-order pipeline.
// Decides freeze / redirect / fetch-stall / advance; owns fetch PC, valid bits, retire order and perf counters.
module pipeline_ctrl #(
  parameter int          NUM_STAGES  = 5,
  parameter int          FLUSH_DEPTH = 2,
  parameter logic [31:0] RESET_PC    = 32'h1eceb000,
  parameter int          ORDER_W     = 64,
  parameter int          PERF_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imem_stall,
  input  logic                  imem_resp,
  input  logic                  dmem_stall,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic [31:0]           pc,
  output logic [NUM_STAGES-2:0] stage_en,
  output logic [NUM_STAGES-2:0] stage_valid,
  output logic                  drop_fetch,
  output logic                  retire,
  output logic [ORDER_W-1:0]    order,
  output logic [PERF_W-1:0]     stall_cycles,
  output logic [PERF_W-1:0]     flush_count
);

  localparam int NR = NUM_STAGES - 1;
  // Registers at or beyond FLUSH_DEPTH survive a redirect.
  localparam logic [NR-1:0] KEEP_MASK = {NR{1'b1}} << FLUSH_DEPTH;

  typedef enum logic [1:0] {
    MODE_FREEZE      = 2'd0,
    MODE_REDIRECT    = 2'd1,
    MODE_FETCH_STALL = 2'd2,
    MODE_ADVANCE     = 2'd3
  } mode_t;

  mode_t          mode;
  logic [NR-1:0]  load_en;
  logic [NR-1:0]  shifted;
  logic [NR-1:0]  valid_next;
  logic [31:0]    pc_next;
  logic           drop_next;

  always_comb begin
    mode = MODE_ADVANCE;
    if (dmem_stall) begin
      mode = MODE_FREEZE;
    end else if (redirect_valid) begin
      mode = MODE_REDIRECT;
    end else if (imem_stall) begin
      mode = MODE_FETCH_STALL;
    end else begin
      mode = MODE_ADVANCE;
    end
  end

  always_comb begin
    load_en    = '0;
    valid_next = stage_valid;
    pc_next    = pc;
    drop_next  = drop_fetch;
    shifted    = {stage_valid[NR-2:0], ~drop_fetch};
    case (mode)
      MODE_FREEZE: begin
        load_en = '0;
      end
      MODE_REDIRECT: begin
        load_en    = '1;
        valid_next = shifted & KEEP_MASK;
        pc_next    = redirect_pc;
        // The fetch already in flight belongs to the old path unless it lands now.
        drop_next  = drop_fetch | imem_stall | ~imem_resp;
      end
      MODE_FETCH_STALL: begin
        load_en       = {{(NR-1){1'b1}}, 1'b0};
        valid_next    = shifted;
        valid_next[0] = stage_valid[0];
        valid_next[1] = 1'b0;
        drop_next     = imem_resp ? 1'b0 : drop_fetch;
      end
      MODE_ADVANCE: begin
        load_en    = '1;
        valid_next = shifted;
        pc_next    = pc + 32'd4;
        drop_next  = imem_resp ? 1'b0 : drop_fetch;
      end
      default: begin
        load_en = '0;
      end
    endcase
  end

  assign stage_en = rst ? '0 : load_en;
  assign retire   = stage_valid[NR-1] & ~dmem_stall & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      stage_valid  <= '0;
      drop_fetch   <= 1'b0;
      order        <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      pc          <= pc_next;
      stage_valid <= valid_next;
      drop_fetch  <= drop_next;
      if (retire) begin
        order <= order + ORDER_W'(1);
      end
      // Perf counters stick at all-ones instead of wrapping.
      if ((dmem_stall || imem_stall) && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + PERF_W'(1);
      end
      if ((mode == MODE_REDIRECT) && (flush_count != '1)) begin
        flush_count <= flush_count + PERF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: drives a default pipeline_ctrl and a 7-stage/FLUSH_DEPTH=3/ORDER_W=8 one with the
// same inputs; a behavioural model queues expected post-edge state that is popped and compared after each edge.
module tb_pipeline_ctrl;

  localparam logic [31:0] RPC = 32'h1eceb000;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  valid;
    logic        drop;
    logic [63:0] order;
    logic [31:0] stall;
    logic [31:0] flush;
  } mstate_t;

  typedef struct packed {
    mstate_t a;
    mstate_t b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_stall = 1'b0;
  logic        imem_resp = 1'b0;
  logic        dmem_stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  logic [31:0] a_pc, b_pc;
  logic [3:0]  a_en, a_valid;
  logic [5:0]  b_en, b_valid;
  logic        a_drop, b_drop, a_retire, b_retire;
  logic [63:0] a_order;
  logic [7:0]  b_order;
  logic [31:0] a_stall, a_flush, b_stall, b_flush;

  int n_checks = 0;
  int n_errors = 0;
  mstate_t ma = '0;
  mstate_t mb = '0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  pipeline_ctrl dut_a (
    .clk(clk), .rst(rst), .imem_stall(imem_stall), .imem_resp(imem_resp),
    .dmem_stall(dmem_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc(a_pc), .stage_en(a_en), .stage_valid(a_valid), .drop_fetch(a_drop),
    .retire(a_retire), .order(a_order), .stall_cycles(a_stall), .flush_count(a_flush)
  );

  pipeline_ctrl #(.NUM_STAGES(7), .FLUSH_DEPTH(3), .ORDER_W(8)) dut_b (
    .clk(clk), .rst(rst), .imem_stall(imem_stall), .imem_resp(imem_resp),
    .dmem_stall(dmem_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc(b_pc), .stage_en(b_en), .stage_valid(b_valid), .drop_fetch(b_drop),
    .retire(b_retire), .order(b_order), .stall_cycles(b_stall), .flush_count(b_flush)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic mstate_t model_step(input mstate_t s, input int nr, input int fd,
                                         input logic r, input logic ds, input logic is,
                                         input logic rv, input logic [31:0] rpc, input logic ir);
    mstate_t n;
    n = s;
    if (r) begin
      n = '0;
      n.pc = RPC;
      return n;
    end
    if ((ds || is) && (n.stall != 32'hffffffff)) n.stall = n.stall + 32'd1;
    if (s.valid[nr-1] && !ds) n.order = n.order + 64'd1;
    if (ds) return n;
    if (rv) begin
      for (int k = 0; k < nr; k++) begin
        if (k < fd) n.valid[k] = 1'b0;
        else n.valid[k] = s.valid[k-1];
      end
      n.pc = rpc;
      if (n.flush != 32'hffffffff) n.flush = n.flush + 32'd1;
      if (is || !ir) n.drop = 1'b1;
    end else if (is) begin
      for (int k = 2; k < nr; k++) n.valid[k] = s.valid[k-1];
      n.valid[1] = 1'b0;
      if (ir) n.drop = 1'b0;
    end else begin
      for (int k = 1; k < nr; k++) n.valid[k] = s.valid[k-1];
      n.valid[0] = !s.drop;
      n.pc = s.pc + 32'd4;
      if (ir) n.drop = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [7:0] model_en(input int nr, input logic r, input logic ds,
                                          input logic is, input logic rv);
    logic [7:0] all;
    all = 8'hff >> (8 - nr);
    if (r || ds) return 8'h00;
    if (rv) return all;
    if (is) return all & 8'hfe;
    return all;
  endfunction

  task automatic step(input logic r, input logic ds, input logic is, input logic rv,
                      input logic [31:0] rpc, input logic ir);
    exp_t e;
    @(negedge clk);
    rst = r; dmem_stall = ds; imem_stall = is; redirect_valid = rv; redirect_pc = rpc; imem_resp = ir;
    #1;
    check_eq("a_stage_en", 64'(a_en), 64'(model_en(4, r, ds, is, rv)));
    check_eq("b_stage_en", 64'(b_en), 64'(model_en(6, r, ds, is, rv)));
    check_eq("a_retire", 64'(a_retire), 64'(ma.valid[3] & ~ds & ~r));
    check_eq("b_retire", 64'(b_retire), 64'(mb.valid[5] & ~ds & ~r));
    e.a = model_step(ma, 4, 2, r, ds, is, rv, rpc, ir);
    e.b = model_step(mb, 6, 3, r, ds, is, rv, rpc, ir);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    ma = e.a;
    mb = e.b;
    check_eq("a_pc", 64'(a_pc), 64'(ma.pc));
    check_eq("a_valid", 64'(a_valid), 64'(ma.valid[3:0]));
    check_eq("a_drop", 64'(a_drop), 64'(ma.drop));
    check_eq("a_order", a_order, ma.order);
    check_eq("a_stall", 64'(a_stall), 64'(ma.stall));
    check_eq("a_flush", 64'(a_flush), 64'(ma.flush));
    check_eq("b_pc", 64'(b_pc), 64'(mb.pc));
    check_eq("b_valid", 64'(b_valid), 64'(mb.valid[5:0]));
    check_eq("b_drop", 64'(b_drop), 64'(mb.drop));
    check_eq("b_order", 64'(b_order), 64'(mb.order[7:0]));
    check_eq("b_stall", 64'(b_stall), 64'(mb.stall));
    check_eq("b_flush", 64'(b_flush), 64'(mb.flush));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    logic ds, is, rv, r;
    // Reset, then the idle PC walk.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h12345678, 1'b0);
    check_eq("reset_pc", 64'(a_pc), 64'(32'h1eceb000));
    check_eq("reset_valid", 64'(a_valid), 64'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("idle_pc", 64'(a_pc), 64'(32'h1eceb000 + 32'(4 * (i + 1))));
    end
    check_eq("idle_order", a_order, 64'd2);

    // Data-memory freeze with a full pipe.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("freeze_stall_cycles", 64'(a_stall), 64'd3);
    check_eq("freeze_pc", 64'(a_pc), 64'(32'h1eceb018));

    // Plain redirect.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h1eceb100, 1'b1);
    check_eq("redir_pc", 64'(a_pc), 64'(32'h1eceb100));
    check_eq("redir_valid_front", 64'(a_valid[1:0]), 64'd0);
    check_eq("redir_flush", 64'(a_flush), 64'd1);
    check_eq("redir_drop", 64'(a_drop), 64'd0);
    idle(4);

    // Redirect while fetch is stalled; the response lands two cycles later.
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h1eceb200, 1'b0);
    check_eq("stale_drop_set", 64'(a_drop), 64'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("stale_reg0_invalid", 64'(a_valid[0]), 64'd0);
    check_eq("stale_drop_clear", 64'(a_drop), 64'd0);
    idle(2);

    // Redirect masked by dmem_stall, then accepted one cycle later.
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h1eceb300, 1'b1);
    check_eq("masked_redir_pc", 64'(a_pc), 64'(ma.pc));
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h1eceb300, 1'b1);
    check_eq("late_redir_pc", 64'(a_pc), 64'(32'h1eceb300));

    // Reset landing mid-stall with a stale fetch pending.
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h1eceb400, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h1eceb500, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("post_reset_pc", 64'(a_pc), 64'(32'h1eceb004));
    check_eq("post_reset_valid0", 64'(a_valid), 64'd1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      ds = ($urandom_range(0, 9) < 2);
      is = ($urandom_range(0, 9) < 2);
      rv = ($urandom_range(0, 9) < 2);
      r  = ($urandom_range(0, 99) < 2);
      step(r, ds, is, rv, $urandom() & 32'hfffffffc, ~is & ($urandom_range(0, 9) < 8));
    end

    // 300 retires on the 8-bit order counter wrap to 44; then the 3-deep squash.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(306);
    check_eq("b_order_wrap", 64'(b_order), 64'd44);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h00000040, 1'b1);
    check_eq("b_squash", 64'(b_valid), 64'(6'b111000));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter NUM_STAGES, default 5, pipeline depth; pipeline registers NR = NUM_STAGES-1, indexed 0 (IF/ID) .. NR-1 (MEM/WB); legal range 3..8.
REQ-002 Parameter FLUSH_DEPTH, default 2, number of front registers (0..FLUSH_DEPTH-1) squashed on redirect; legal 1..NR-1.
REQ-003 Parameter RESET_PC, default 32'h1eceb000, fetch PC after reset.
REQ-004 Parameter ORDER_W, default 64, retire-order counter width.
REQ-005 Parameter PERF_W, default 32, performance counter width.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 imem_stall  in  1  fetch response not yet available this cycle.
REQ-009 imem_resp  in  1  instruction memory returned data this cycle.
REQ-010 dmem_stall  in  1  memory stage waiting on data memory.
REQ-011 redirect_valid  in  1  branch/jump taken, resolved in execute.
REQ-012 redirect_pc  in  32  redirect target.
REQ-013 pc  out  32  current fetch PC.
REQ-014 stage_en  out  NR  load enable per pipeline register.
REQ-015 stage_valid  out  NR  valid bit held in each pipeline register.
REQ-016 drop_fetch  out  1  in-flight fetch data is stale; decode must not consume it.
REQ-017 retire  out  1  instruction in register NR-1 commits this cycle.
REQ-018 order  out  ORDER_W  retire order of instruction in register NR-1.
REQ-019 stall_cycles, flush_count  out  PERF_W each  saturating performance counters.

Function
REQ-020 Priority per cycle: dmem_stall > redirect_valid > imem_stall > normal advance.
REQ-021 dmem_stall=1: freeze -- stage_en all 0, pc, stage_valid, drop_fetch, order held; redirect_valid ignored that cycle (execute is frozen and re-asserts).
REQ-022 Normal advance (no stall/redirect): stage_en all 1; stage_valid[0] <= ~drop_fetch; stage_valid[k] <= stage_valid[k-1] for k>=1; pc <= pc+4 (32-bit wrap).
REQ-023 imem_stall=1, no redirect: stage_en[0]=0 (register 0 holds), stage_valid[1] <= 0 (bubble), registers k>=2 advance as REQ-022; pc held.
REQ-024 Redirect accepted (redirect_valid=1, dmem_stall=0), with or without imem_stall: stage_valid[0..FLUSH_DEPTH-1] <= 0, registers k>=FLUSH_DEPTH advance; pc <= redirect_pc; flush_count increments.
REQ-025 drop_fetch: set on accepted redirect when imem_stall=1 or imem_resp=0 that cycle; cleared on first later non-frozen cycle with imem_resp=1; redirect in the clearing cycle keeps it set.
REQ-026 retire = stage_valid[NR-1] & ~dmem_stall; combinational.
REQ-027 order increments by 1 on the edge ending each retire cycle, wraps at 2^ORDER_W.
REQ-028 stall_cycles increments every cycle dmem_stall=1 or imem_stall=1 (not in reset); both counters saturate at all-ones.
REQ-029 stage_en[k] for k>=FLUSH_DEPTH is 1 whenever dmem_stall=0.
REQ-030 No combinational path from redirect_pc to any output except via pc register.

Reset
REQ-031 rst=1 at edge: pc=RESET_PC, stage_valid=0, drop_fetch=0, order=0, stall_cycles=0, flush_count=0; rst overrides all inputs.
REQ-032 During rst, stage_en=0 and retire=0.
REQ-033 Reset asserted mid-stall or mid-redirect fully discards pending state; first post-reset cycle behaves as REQ-022 from RESET_PC.

Verification
REQ-034 Reset then 6 idle cycles -> pc 1eceb000,..04,..08,...; stage_valid[NR-1] first 1 on cycle NR; order 0 then 1 after first retire.
REQ-035 dmem_stall held 3 cycles with all registers valid -> outputs frozen, retire=0, stall_cycles=3, order unchanged.
REQ-036 redirect_valid=1, redirect_pc=32'h1eceb100, no stalls -> next pc 1eceb100, stage_valid[0..1]=0, flush_count=1, drop_fetch=0.
REQ-037 Redirect during imem_stall, imem_resp arrives 2 cycles later -> drop_fetch 1 for those cycles, register 0 loaded invalid once, clears after imem_resp.
REQ-038 redirect_valid and dmem_stall together -> redirect ignored, pc held; redirect one cycle after stall -> accepted.
REQ-039 Parameters NUM_STAGES=7, FLUSH_DEPTH=3, ORDER_W=8: 300 retires wrap order to 44; redirect squashes registers 0..2 only.
